// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Glyph codes are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef enum logic {
        S_DEAD  = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'b111_1111;

    localparam logic [6:0] GLYPH_LUT [0:15] = '{
        7'b100_0000,  // 0
        7'b111_1001,  // 1
        7'b010_0100,  // 2
        7'b011_0000,  // 3
        7'b001_1001,  // 4
        7'b001_0010,  // 5
        7'b000_0010,  // 6
        7'b111_1000,  // 7
        7'b000_0000,  // 8
        7'b001_1000,  // 9
        7'b000_1000,  // A
        7'b000_0011,  // b
        7'b100_0110,  // C
        7'b010_0001,  // d
        7'b000_0110,  // E
        7'b000_1110   // F
    };

endpackage

// File: rtl/seg7_glyph.sv
// Nibble to active-low seven-segment code, with blanking and an optional hex range.
module seg7_glyph
    import seg7_pkg::*;
#(
    parameter bit HEX_EN = 1'b0
) (
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] code
);

    // Blanked digits and non-decimal nibbles without hex support show nothing.
    always_comb begin
        code = SEG_OFF;
        if (blank) begin
            code = SEG_OFF;
        end else if ((nibble > 4'd9) && !HEX_EN) begin
            code = SEG_OFF;
        end else begin
            code = GLYPH_LUT[nibble];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode display driver: shadow registers, scan FSM,
// leading-zero suppression, blink and registered polarity-adjusted outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2,
    parameter int BLINK_DIV   = 12500000,
    parameter bit HEX_EN      = 1'b0,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      lz_en,
    input  logic                      blink_en,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an
);

    localparam int CNT_MAX0 = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
    localparam int CW       = $clog2(CNT_MAX);
    localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW       = $clog2(BLINK_DIV);

    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST    = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    // Internal codes are active-low; XOR masks flip them for active-high boards.
    localparam logic [6:0]            SEG_INV = ACTIVE_LOW ? 7'b000_0000 : 7'b111_1111;
    localparam logic                  DP_INV  = ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic [NUM_DIGITS-1:0] AN_INV  = ACTIVE_LOW ? {NUM_DIGITS{1'b0}} : {NUM_DIGITS{1'b1}};
    localparam logic [6:0]            SEG_IDLE = SEG_OFF ^ SEG_INV;
    localparam logic                  DP_IDLE  = 1'b1 ^ DP_INV;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{1'b1}} ^ AN_INV;

    logic [4*NUM_DIGITS-1:0] value_r;
    logic [NUM_DIGITS-1:0]   dp_r;
    logic                    lz_r;

    scan_state_e             state_r;
    logic [CW-1:0]           cnt_r;
    logic [IW-1:0]           idx_r;
    logic [BW-1:0]           blink_cnt_r;
    logic                    blink_phase_r;

    logic [6:0]              seg_r;
    logic                    dp_out_r;
    logic [NUM_DIGITS-1:0]   an_r;

    logic [NUM_DIGITS-1:0]   supp_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic [IW-1:0]           next_idx_s;
    logic [3:0]              act_nibble_s;
    logic                    act_blank_s;
    logic                    act_dp_s;
    logic [6:0]              glyph_s;

    // Shadow copy of the display data; the last load wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= '0;
            dp_r    <= '0;
            lz_r    <= 1'b0;
        end else if (load) begin
            value_r <= value;
            dp_r    <= dp_in;
            lz_r    <= lz_en;
        end
    end

    // Leading-zero chain: a digit is suppressed only if it and everything above it is zero.
    always_comb begin : lz_chain
        logic run_v;
        run_v  = 1'b1;
        supp_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_v     = run_v & (value_r[4*i +: 4] == 4'd0);
            supp_s[i] = lz_r & run_v & (i != 0);
        end
    end

    // Active-digit select, one-hot enable and wrapping next index.
    always_comb begin
        onehot_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            onehot_s[i] = (idx_r == IW'(i));
        end
        if (idx_r == IDX_LAST) begin
            next_idx_s = '0;
        end else begin
            next_idx_s = idx_r + IW'(1);
        end
        act_nibble_s = value_r[{idx_r, 2'b00} +: 4];
        act_blank_s  = supp_s[idx_r];
        act_dp_s     = dp_r[idx_r];
    end

    seg7_glyph #(
        .HEX_EN (HEX_EN)
    ) u_glyph (
        .nibble (act_nibble_s),
        .blank  (act_blank_s),
        .code   (glyph_s)
    );

    // Free-running blink divider, independent of blink_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= ~blink_phase_r;
        end else begin
            blink_cnt_r   <= blink_cnt_r + BW'(1);
        end
    end

    // Scan FSM with outputs registered from the current state (one cycle behind it).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_DEAD;
            cnt_r    <= '0;
            idx_r    <= IDX_LAST;
            seg_r    <= SEG_IDLE;
            dp_out_r <= DP_IDLE;
            an_r     <= AN_IDLE;
        end else begin
            case (state_r)
                S_DEAD: begin
                    if ((DEAD_CYCLES == 0) || (cnt_r == DEAD_LAST)) begin
                        state_r <= S_DRIVE;
                        cnt_r   <= '0;
                        idx_r   <= next_idx_s;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                    end
                    seg_r    <= SEG_IDLE;
                    dp_out_r <= DP_IDLE;
                    an_r     <= AN_IDLE;
                end
                S_DRIVE: begin
                    if (cnt_r == REFRESH_LAST) begin
                        cnt_r <= '0;
                        if (DEAD_CYCLES == 0) begin
                            idx_r <= next_idx_s;
                        end else begin
                            state_r <= S_DEAD;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                    seg_r    <= glyph_s ^ SEG_INV;
                    dp_out_r <= (~act_dp_s) ^ DP_INV;
                    if (blink_en && blink_phase_r) begin
                        an_r <= AN_IDLE;
                    end else begin
                        an_r <= (~onehot_s) ^ AN_INV;
                    end
                end
                default: begin
                    state_r  <= S_DEAD;
                    cnt_r    <= '0;
                    idx_r    <= IDX_LAST;
                    seg_r    <= SEG_IDLE;
                    dp_out_r <= DP_IDLE;
                    an_r     <= AN_IDLE;
                end
            endcase
        end
    end

    assign seg = seg_r;
    assign dp  = dp_out_r;
    assign an  = an_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver: two instances (hex on/off) checked every
// cycle against a slot/time-based model, plus pinned literal expectations.
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int R = 4;
    localparam int D = 1;
    localparam int B = 64;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic        blink_en;

    logic [6:0]  seg_h, seg_n;
    logic        dp_h, dp_n;
    logic [3:0]  an_h, an_n;

    int checks = 0;
    int errors = 0;

    // Model state: edges since reset release and the shadow copy.
    int          k;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic        m_lz;
    logic [11:0] exp_h, exp_n;

    seg7_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .BLINK_DIV(B),
        .HEX_EN(1'b1), .ACTIVE_LOW(1'b1)
    ) dut_hex (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .lz_en(lz_en), .blink_en(blink_en), .seg(seg_h), .dp(dp_h), .an(an_h)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .BLINK_DIV(B),
        .HEX_EN(1'b0), .ACTIVE_LOW(1'b1)
    ) dut_dec (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .lz_en(lz_en), .blink_en(blink_en), .seg(seg_n), .dp(dp_n), .an(an_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        case (nib)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0011000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Outputs seen after edge k+1, from time position k: each slot is D dead then R driven.
    function automatic logic [11:0] model_out(input int kk, input logic [15:0] v,
                                              input logic [3:0] d, input logic lz,
                                              input logic be, input bit hex);
        int pos, slot;
        logic [3:0] nib;
        logic [6:0] s;
        logic [3:0] a;
        logic [15:0] upper;
        pos  = kk % (R + D);
        slot = (kk / (R + D)) % N;
        if (pos < D) return {7'h7F, 1'b1, 4'hF};
        nib   = v[slot*4 +: 4];
        upper = v >> (4 * slot);
        if (lz && slot != 0 && upper == 16'd0) s = 7'h7F;
        else if (nib > 4'd9 && !hex)            s = 7'h7F;
        else                                    s = glyph(nib);
        a = (be && ((kk / B) % 2 == 1)) ? 4'hF : ~(4'b0001 << slot);
        return {s, ~d[slot], a};
    endfunction

    initial begin
        k = 0; m_val = '0; m_dp = '0; m_lz = 1'b0;
        exp_h = 12'hFFF; exp_n = 12'hFFF;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k = 0; m_val = '0; m_dp = '0; m_lz = 1'b0;
                exp_h = 12'hFFF; exp_n = 12'hFFF;
            end else begin
                exp_h = model_out(k, m_val, m_dp, m_lz, blink_en, 1'b1);
                exp_n = model_out(k, m_val, m_dp, m_lz, blink_en, 1'b0);
                k = k + 1;
                if (load) begin
                    m_val = value; m_dp = dp_in; m_lz = lz_en;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checks = checks + 2;
            if ({seg_h, dp_h, an_h} !== exp_h) begin
                errors = errors + 1;
                $display("FAIL hex_model seg/dp/an=%b/%b/%b required=%b/%b/%b k=%0d",
                         seg_h, dp_h, an_h, exp_h[11:5], exp_h[4], exp_h[3:0], k);
            end
            if ({seg_n, dp_n, an_n} !== exp_n) begin
                errors = errors + 1;
                $display("FAIL dec_model seg/dp/an=%b/%b/%b required=%b/%b/%b k=%0d",
                         seg_n, dp_n, an_n, exp_n[11:5], exp_n[4], exp_n[3:0], k);
            end
        end
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic wait_an(input logic [3:0] target, input int maxc, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < maxc && !hit; i++) begin
            @(negedge clk);
            if (an_h === target) hit = 1'b1;
        end
        checks = checks + 1;
        if (!hit) begin
            errors = errors + 1;
            $display("FAIL %s_timeout an=%b required=%b", tag, an_h, target);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
        @(negedge clk);
        value = v; dp_in = d; lz_en = lz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        logic [15:0] mask;
        bit          hit;
        rst_n = 1'b0; load = 1'b0; value = '0; dp_in = '0; lz_en = 1'b0; blink_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_hex", {seg_h, dp_h, an_h}, 12'hFFF);
        chk("reset_dec", {seg_n, dp_n, an_n}, 12'hFFF);
        rst_n = 1'b1;

        // Plain decimal scan.
        do_load(16'h1234, 4'b0000, 1'b0);
        wait_an(4'b1110, 30, "d0_1234");
        chk("digit0_is_4", {seg_h, an_h}, {7'b0011001, 4'b1110});
        wait_an(4'b0111, 30, "d3_1234");
        chk("digit3_is_1", {seg_n, an_n}, {7'b1111001, 4'b0111});
        repeat (20) @(negedge clk);

        // Leading-zero suppression.
        do_load(16'h0050, 4'b0000, 1'b1);
        wait_an(4'b0111, 30, "lz_d3");
        chk("lz_digit3_blank", {seg_h, an_h}, {7'b1111111, 4'b0111});
        wait_an(4'b1101, 30, "lz_d1");
        chk("lz_digit1_is_5", {seg_h, an_h}, {7'b0010010, 4'b1101});
        do_load(16'h0000, 4'b0000, 1'b1);
        wait_an(4'b1110, 30, "lz_zero_d0");
        chk("lz_zero_digit0", {seg_h, an_h}, {7'b1000000, 4'b1110});
        repeat (20) @(negedge clk);

        // Hex glyphs versus blanking.
        do_load(16'hABCF, 4'b0000, 1'b0);
        wait_an(4'b1110, 30, "hex_d0");
        chk("hex_digit0_F", {seg_h, an_h}, {7'b0001110, 4'b1110});
        chk("dec_digit0_blank", {seg_n, an_n}, {7'b1111111, 4'b1110});
        wait_an(4'b0111, 30, "hex_d3");
        chk("hex_digit3_A", seg_h, 7'b0001000);
        repeat (10) @(negedge clk);

        // Blink windows.
        blink_en = 1'b1;
        repeat (200) @(negedge clk);
        blink_en = 1'b0;

        // Randomized loads, including back-to-back loads.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            @(negedge clk);
            value = 16'($urandom) & mask;
            dp_in = 4'($urandom);
            lz_en = 1'($urandom);
            blink_en = ($urandom_range(0, 3) == 0);
            load = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                value = 16'($urandom);
            end
            @(negedge clk);
            load = 1'b0;
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        blink_en = 1'b0;

        // Load sampled on the very edge where the scan enters the next digit.
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (k % (R + D) == 0) hit = 1'b1;
        end
        chk("advance_edge_found", {11'd0, hit}, 12'd1);
        value = 16'h9999; dp_in = 4'b0100; lz_en = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        chk("first_drive_is_9", seg_h, 7'b0011000);
        wait_an(4'b1011, 30, "dp_d2");
        chk("dp_on_digit2", {dp_h, an_h}, {1'b0, 4'b1011});
        wait_an(4'b0111, 30, "dp_d3");
        chk("dp_off_digit3", {dp_h, an_h}, {1'b1, 4'b0111});

        // Asynchronous reset in the middle of a driven digit.
        wait_an(4'b1101, 30, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_hex", {seg_h, dp_h, an_h}, 12'hFFF);
        chk("async_reset_dec", {seg_n, dp_n, an_n}, 12'hFFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (an_h !== 4'b1111) hit = 1'b1;
        end
        chk("post_reset_digit0", {seg_h, dp_h, an_h}, {7'b1000000, 1'b1, 4'b1110});
        repeat (25) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
